// File: rtl/change_pkg.sv
// ---------------------------------------------------------------------------
// change_pkg
// Shared types for the change dispenser: the coin selector encoding used on
// the ejector interface and the refill port, and the controller state type.
// ---------------------------------------------------------------------------
package change_pkg;

  // Coin encoding seen by the ejector and by the refill bin selector.
  typedef enum logic [1:0] {
    COIN_LO  = 2'd0,
    COIN_MID = 2'd1,
    COIN_HI  = 2'd2
  } coin_sel_t;

  // Controller states.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DISP = 2'd2,
    DONE = 2'd3
  } state_t;

endpackage

// File: rtl/coin_inventory.sv
// ---------------------------------------------------------------------------
// coin_inventory
// Three per-denomination coin counters. Counts saturate at the top of their
// range on refill and drop by one when a coin leaves the selected bin.
// Ports:
//   clk          clock
//   rst_n        synchronous active-low reset, all counts return to INIT_CNT
//   refill       add refill_cnt coins to the refill_sel bin (3 = no bin)
//   refill_sel   bin to refill
//   refill_cnt   number of coins to add
//   take         remove one coin from the take_sel bin
//   take_sel     bin the coin is taken from
//   inv_lo/mid/hi current counts
// ---------------------------------------------------------------------------
module coin_inventory
  import change_pkg::*;
#(
  parameter int CNT_W    = 4,
  parameter int INIT_CNT = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             refill,
  input  logic [1:0]       refill_sel,
  input  logic [CNT_W-1:0] refill_cnt,
  input  logic             take,
  input  coin_sel_t        take_sel,
  output logic [CNT_W-1:0] inv_lo,
  output logic [CNT_W-1:0] inv_mid,
  output logic [CNT_W-1:0] inv_hi
);

  localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(INIT_CNT);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  // One extra bit catches the carry out; any carry means the bin is full.
  function automatic logic [CNT_W-1:0] sat_add(input logic [CNT_W-1:0] a,
                                               input logic [CNT_W-1:0] b);
    logic [CNT_W:0] sum;
    sum = {1'b0, a} + {1'b0, b};
    return sum[CNT_W] ? {CNT_W{1'b1}} : sum[CNT_W-1:0];
  endfunction

  // Refill and take never coincide in practice (refill is gated to the idle
  // state, take happens only while a coin is dispensed), but both paths are
  // kept independent so neither can mask the other on a different bin.
  // The controller only takes from a bin it has seen non-empty, so the
  // decrement can not wrap.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      inv_lo  <= CNT_INIT;
      inv_mid <= CNT_INIT;
      inv_hi  <= CNT_INIT;
    end else begin
      if (refill) begin
        case (refill_sel)
          2'd0:    inv_lo  <= sat_add(inv_lo, refill_cnt);
          2'd1:    inv_mid <= sat_add(inv_mid, refill_cnt);
          2'd2:    inv_hi  <= sat_add(inv_hi, refill_cnt);
          default: ;
        endcase
      end
      if (take) begin
        case (take_sel)
          COIN_LO:  inv_lo  <= inv_lo - CNT_ONE;
          COIN_MID: inv_mid <= inv_mid - CNT_ONE;
          COIN_HI:  inv_hi  <= inv_hi - CNT_ONE;
          default:  ;
        endcase
      end
    end
  end

endmodule

// File: rtl/change_dispenser.sv
// ---------------------------------------------------------------------------
// change_dispenser
// Computes the change owed for a purchase (or a full refund when the money
// does not cover the price) and pays it out greedily, one coin per
// valid/ready handshake, from a refillable per-denomination inventory.
// Ports:
//   clk_i, rst_n_i          clock, synchronous active-low reset
//   start_i                 begin a transaction with price_i/money_i (idle only)
//   price_i, money_i        item price and money inserted
//   coin_valid_o            coin offered to the ejector
//   coin_sel_o              offered coin: 0=LO, 1=MID, 2=HI
//   coin_ready_i            ejector takes the offered coin
//   busy_o                  transaction in progress
//   done_o                  one-cycle end-of-transaction pulse
//   short_o, remainder_o    exact change impossible / amount left unpaid
//   refill_i, refill_sel_i, refill_cnt_i  add coins to a bin (idle only)
//   inv_lo_o/inv_mid_o/inv_hi_o           current inventory
// ---------------------------------------------------------------------------
module change_dispenser
  import change_pkg::*;
#(
  parameter int MONEY_W  = 5,
  parameter int CNT_W    = 4,
  parameter int D_HI     = 10,
  parameter int D_MID    = 5,
  parameter int D_LO     = 1,
  parameter int INIT_CNT = 4
) (
  input  logic               clk_i,
  input  logic               rst_n_i,
  input  logic               start_i,
  input  logic [MONEY_W-1:0] price_i,
  input  logic [MONEY_W-1:0] money_i,
  output logic               coin_valid_o,
  output logic [1:0]         coin_sel_o,
  input  logic               coin_ready_i,
  output logic               busy_o,
  output logic               done_o,
  output logic               short_o,
  output logic [MONEY_W-1:0] remainder_o,
  input  logic               refill_i,
  input  logic [1:0]         refill_sel_i,
  input  logic [CNT_W-1:0]   refill_cnt_i,
  output logic [CNT_W-1:0]   inv_lo_o,
  output logic [CNT_W-1:0]   inv_mid_o,
  output logic [CNT_W-1:0]   inv_hi_o
);

  localparam logic [MONEY_W-1:0] VAL_HI  = MONEY_W'(D_HI);
  localparam logic [MONEY_W-1:0] VAL_MID = MONEY_W'(D_MID);
  localparam logic [MONEY_W-1:0] VAL_LO  = MONEY_W'(D_LO);

  state_t             state;
  state_t             state_next;
  logic [MONEY_W-1:0] rem;
  coin_sel_t          sel;
  coin_sel_t          pick;
  logic               pick_ok;
  logic               short_q;
  logic [MONEY_W-1:0] remainder_q;
  logic               accept;
  logic               refill_ok;

  function automatic logic [MONEY_W-1:0] coin_value(input coin_sel_t s);
    case (s)
      COIN_HI:  return VAL_HI;
      COIN_MID: return VAL_MID;
      default:  return VAL_LO;
    endcase
  endfunction

  // Inventory: refills only land while idle, coins leave on each handshake.
  coin_inventory #(
    .CNT_W    (CNT_W),
    .INIT_CNT (INIT_CNT)
  ) u_inventory (
    .clk        (clk_i),
    .rst_n      (rst_n_i),
    .refill     (refill_ok),
    .refill_sel (refill_sel_i),
    .refill_cnt (refill_cnt_i),
    .take       (accept),
    .take_sel   (sel),
    .inv_lo     (inv_lo_o),
    .inv_mid    (inv_mid_o),
    .inv_hi     (inv_hi_o)
  );

  // Greedy choice: biggest coin that fits the remaining amount and is in
  // stock. D_LO >= 1, so a zero remainder never picks a coin.
  always_comb begin
    pick    = COIN_LO;
    pick_ok = 1'b0;
    if (rem >= VAL_HI && inv_hi_o != '0) begin
      pick    = COIN_HI;
      pick_ok = 1'b1;
    end else if (rem >= VAL_MID && inv_mid_o != '0) begin
      pick    = COIN_MID;
      pick_ok = 1'b1;
    end else if (rem >= VAL_LO && inv_lo_o != '0) begin
      pick    = COIN_LO;
      pick_ok = 1'b1;
    end
  end

  // State register.
  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic: each coin alternates CALC (choose) and DISP (hand over).
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (start_i) state_next = CALC;
      CALC:    state_next = pick_ok ? DISP : DONE;
      DISP:    if (coin_ready_i) state_next = CALC;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // State-decoded outputs and enables.
  always_comb begin
    coin_valid_o = (state == DISP);
    busy_o       = (state != IDLE);
    done_o       = (state == DONE);
    accept       = (state == DISP) && coin_ready_i;
    refill_ok    = refill_i && (state == IDLE);
  end

  // Datapath: remaining amount, selected coin and the shortfall result.
  // The result registers are cleared when a new transaction starts and are
  // otherwise held, so the previous outcome stays readable while idle.
  // The subtraction only follows a CALC pick, which already proved rem >= coin.
  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      rem         <= '0;
      sel         <= COIN_LO;
      short_q     <= 1'b0;
      remainder_q <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start_i) begin
            rem         <= (money_i >= price_i) ? (money_i - price_i) : money_i;
            short_q     <= 1'b0;
            remainder_q <= '0;
          end
        end
        CALC: begin
          if (pick_ok) begin
            sel <= pick;
          end else if (rem != '0) begin
            short_q     <= 1'b1;
            remainder_q <= rem;
          end
        end
        DISP: begin
          if (coin_ready_i) begin
            rem <= rem - coin_value(sel);
          end
        end
        default: ;
      endcase
    end
  end

  assign coin_sel_o  = sel;
  assign short_o     = short_q;
  assign remainder_o = remainder_q;

endmodule

// File: tb/tb_change_dispenser.sv
// ---------------------------------------------------------------------------
// tb_change_dispenser
// Self-checking bench for change_dispenser with default parameters. Expected
// coins are queued before each transaction and popped as the ejector takes
// them; inventory and shortfall results are compared against fixed values.
// ---------------------------------------------------------------------------
module tb_change_dispenser;
  import change_pkg::*;

  logic       clk_i = 1'b0;
  logic       rst_n_i;
  logic       start_i;
  logic [4:0] price_i;
  logic [4:0] money_i;
  logic       coin_valid_o;
  logic [1:0] coin_sel_o;
  logic       coin_ready_i;
  logic       busy_o;
  logic       done_o;
  logic       short_o;
  logic [4:0] remainder_o;
  logic       refill_i;
  logic [1:0] refill_sel_i;
  logic [3:0] refill_cnt_i;
  logic [3:0] inv_lo_o;
  logic [3:0] inv_mid_o;
  logic [3:0] inv_hi_o;

  int checks = 0;
  int passes = 0;
  logic [1:0] exp_q[$];

  change_dispenser dut (
    .clk_i        (clk_i),
    .rst_n_i      (rst_n_i),
    .start_i      (start_i),
    .price_i      (price_i),
    .money_i      (money_i),
    .coin_valid_o (coin_valid_o),
    .coin_sel_o   (coin_sel_o),
    .coin_ready_i (coin_ready_i),
    .busy_o       (busy_o),
    .done_o       (done_o),
    .short_o      (short_o),
    .remainder_o  (remainder_o),
    .refill_i     (refill_i),
    .refill_sel_i (refill_sel_i),
    .refill_cnt_i (refill_cnt_i),
    .inv_lo_o     (inv_lo_o),
    .inv_mid_o    (inv_mid_o),
    .inv_hi_o     (inv_hi_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic apply_reset();
    rst_n_i      = 1'b0;
    start_i      = 1'b0;
    coin_ready_i = 1'b0;
    refill_i     = 1'b0;
    refill_sel_i = 2'd0;
    refill_cnt_i = 4'd0;
    price_i      = 5'd0;
    money_i      = 5'd0;
    repeat (2) @(posedge clk_i);
    #1;
    rst_n_i = 1'b1;
  endtask

  // Drives one transaction and consumes the scoreboard as coins are taken.
  // The ejector stalls the first `stall` offered cycles, then accepts.
  task automatic run_txn(input logic [4:0] price, input logic [4:0] money,
                         input int stall, input logic do_refill,
                         input logic [1:0] rsel, input logic [3:0] rcnt,
                         output logic seen_done, output logic seen_short,
                         output logic [4:0] seen_rem, output int first_cyc,
                         output int done_cyc);
    int stall_left;
    stall_left   = stall;
    seen_done    = 1'b0;
    seen_short   = 1'b0;
    seen_rem     = 5'd0;
    first_cyc    = -1;
    done_cyc     = -1;
    price_i      = price;
    money_i      = money;
    start_i      = 1'b1;
    refill_i     = do_refill;
    refill_sel_i = rsel;
    refill_cnt_i = rcnt;
    @(posedge clk_i);
    #1;
    start_i  = 1'b0;
    refill_i = 1'b0;
    for (int cyc = 0; cyc < 200 && !seen_done; cyc++) begin
      coin_ready_i = (stall_left == 0);
      @(negedge clk_i);
      if (coin_valid_o) begin
        if (first_cyc < 0) first_cyc = cyc;
        checks++;
        if (exp_q.size() == 0)
          $display("[TB] FAIL coin_extra: got sel %0d, required no coin", coin_sel_o);
        else if (coin_sel_o !== exp_q[0])
          $display("[TB] FAIL coin_sel: got %0d, required %0d (cycle %0d)", coin_sel_o, exp_q[0], cyc);
        else
          passes++;
        if (coin_ready_i) begin
          if (exp_q.size() != 0) void'(exp_q.pop_front());
        end else begin
          stall_left--;
        end
      end
      if (done_o) begin
        seen_done  = 1'b1;
        seen_short = short_o;
        seen_rem   = remainder_o;
        done_cyc   = cyc;
      end
      @(posedge clk_i);
      #1;
    end
    coin_ready_i = 1'b0;
    checks++;
    if (!seen_done) $display("[TB] FAIL txn_timeout: got no done_o, required done_o within 200 cycles");
    else passes++;
    checks++;
    if (exp_q.size() != 0) begin
      $display("[TB] FAIL coins_missing: got %0d coins left unpaid, required 0", exp_q.size());
      exp_q.delete();
    end else begin
      passes++;
    end
  endtask

  task automatic test_reset();
    apply_reset();
    @(negedge clk_i);
    checks++;
    if ({inv_hi_o, inv_mid_o, inv_lo_o} !== 12'h444)
      $display("[TB] FAIL reset_inv: got %h, required 444", {inv_hi_o, inv_mid_o, inv_lo_o});
    else passes++;
    checks++;
    if ({coin_valid_o, busy_o, done_o, short_o} !== 4'b0000)
      $display("[TB] FAIL reset_flags: got %b, required 0000", {coin_valid_o, busy_o, done_o, short_o});
    else passes++;
    checks++;
    if ({remainder_o, coin_sel_o} !== 7'd0)
      $display("[TB] FAIL reset_rem_sel: got rem %0d sel %0d, required 0 0", remainder_o, coin_sel_o);
    else passes++;
  endtask

  task automatic test_change();
    logic d, s;
    logic [4:0] r;
    int fc, dc;
    apply_reset();
    exp_q.push_back(COIN_HI);
    exp_q.push_back(COIN_MID);
    exp_q.push_back(COIN_LO);
    exp_q.push_back(COIN_LO);
    exp_q.push_back(COIN_LO);
    run_txn(5'd7, 5'd25, 0, 1'b0, 2'd0, 4'd0, d, s, r, fc, dc);
    checks++;
    if ({s, r} !== 6'd0) $display("[TB] FAIL change_short: got short %0d rem %0d, required 0 0", s, r);
    else passes++;
    checks++;
    if (fc !== 1) $display("[TB] FAIL change_first_coin: got cycle %0d, required 1", fc);
    else passes++;
    checks++;
    if (dc !== 11) $display("[TB] FAIL change_done_cycle: got %0d, required 11", dc);
    else passes++;
    @(negedge clk_i);
    checks++;
    if ({done_o, busy_o} !== 2'b00) $display("[TB] FAIL done_pulse: got done %0d busy %0d, required 0 0", done_o, busy_o);
    else passes++;
    checks++;
    if ({inv_hi_o, inv_mid_o, inv_lo_o} !== 12'h331)
      $display("[TB] FAIL change_inv: got %h, required 331", {inv_hi_o, inv_mid_o, inv_lo_o});
    else passes++;
  endtask

  task automatic test_zero_and_refund();
    logic d, s;
    logic [4:0] r;
    int fc, dc;
    apply_reset();
    run_txn(5'd9, 5'd9, 0, 1'b0, 2'd0, 4'd0, d, s, r, fc, dc);
    checks++;
    if (dc !== 1 || fc !== -1) $display("[TB] FAIL zero_change: got done cycle %0d first coin %0d, required 1 -1", dc, fc);
    else passes++;
    exp_q.push_back(COIN_LO);
    exp_q.push_back(COIN_LO);
    exp_q.push_back(COIN_LO);
    run_txn(5'd7, 5'd3, 0, 1'b0, 2'd0, 4'd0, d, s, r, fc, dc);
    checks++;
    if (s !== 1'b0) $display("[TB] FAIL refund_short: got %0d, required 0", s);
    else passes++;
    @(negedge clk_i);
    checks++;
    if ({inv_hi_o, inv_mid_o, inv_lo_o} !== 12'h441)
      $display("[TB] FAIL refund_inv: got %h, required 441", {inv_hi_o, inv_mid_o, inv_lo_o});
    else passes++;
  endtask

  task automatic test_backpressure();
    logic d, s;
    logic [4:0] r;
    int fc, dc;
    apply_reset();
    exp_q.push_back(COIN_LO);
    run_txn(5'd5, 5'd6, 5, 1'b0, 2'd0, 4'd0, d, s, r, fc, dc);
    checks++;
    if (dc !== 8) $display("[TB] FAIL stall_done_cycle: got %0d, required 8", dc);
    else passes++;
    @(negedge clk_i);
    checks++;
    if ({inv_hi_o, inv_mid_o, inv_lo_o} !== 12'h443)
      $display("[TB] FAIL stall_inv: got %h, required 443", {inv_hi_o, inv_mid_o, inv_lo_o});
    else passes++;
  endtask

  task automatic test_shortfall();
    logic d, s;
    logic [4:0] r;
    int fc, dc;
    apply_reset();
    repeat (2) begin
      exp_q.push_back(COIN_HI);
      exp_q.push_back(COIN_HI);
      run_txn(5'd5, 5'd25, 0, 1'b0, 2'd0, 4'd0, d, s, r, fc, dc);
    end
    // HI bin empty; a refill in the start cycle must be visible to the pick.
    exp_q.push_back(COIN_HI);
    run_txn(5'd5, 5'd15, 0, 1'b1, 2'd2, 4'd1, d, s, r, fc, dc);
    @(negedge clk_i);
    checks++;
    if ({inv_hi_o, inv_mid_o, inv_lo_o} !== 12'h044)
      $display("[TB] FAIL refill_start_inv: got %h, required 044", {inv_hi_o, inv_mid_o, inv_lo_o});
    else passes++;
    repeat (2) begin
      exp_q.push_back(COIN_MID);
      exp_q.push_back(COIN_MID);
      run_txn(5'd5, 5'd15, 0, 1'b0, 2'd0, 4'd0, d, s, r, fc, dc);
    end
    exp_q.push_back(COIN_LO);
    exp_q.push_back(COIN_LO);
    run_txn(5'd1, 5'd3, 0, 1'b0, 2'd0, 4'd0, d, s, r, fc, dc);
    @(negedge clk_i);
    checks++;
    if ({inv_hi_o, inv_mid_o, inv_lo_o} !== 12'h002)
      $display("[TB] FAIL drain_inv: got %h, required 002", {inv_hi_o, inv_mid_o, inv_lo_o});
    else passes++;
    exp_q.push_back(COIN_LO);
    exp_q.push_back(COIN_LO);
    run_txn(5'd1, 5'd5, 0, 1'b0, 2'd0, 4'd0, d, s, r, fc, dc);
    checks++;
    if ({s, r} !== {1'b1, 5'd2}) $display("[TB] FAIL short_result: got short %0d rem %0d, required 1 2", s, r);
    else passes++;
    @(negedge clk_i);
    checks++;
    if ({short_o, remainder_o} !== {1'b1, 5'd2})
      $display("[TB] FAIL short_hold: got short %0d rem %0d, required 1 2", short_o, remainder_o);
    else passes++;
    run_txn(5'd3, 5'd3, 0, 1'b0, 2'd0, 4'd0, d, s, r, fc, dc);
    checks++;
    if ({s, r} !== 6'd0) $display("[TB] FAIL short_clear: got short %0d rem %0d, required 0 0", s, r);
    else passes++;
  endtask

  task automatic test_refill_and_reset();
    logic d, s;
    logic [4:0] r;
    int fc, dc;
    apply_reset();
    refill_i = 1'b1; refill_sel_i = 2'd0; refill_cnt_i = 4'd10;
    @(posedge clk_i); #1;
    refill_i = 1'b0;
    @(negedge clk_i);
    checks++;
    if (inv_lo_o !== 4'd14) $display("[TB] FAIL refill_add: got %0d, required 14", inv_lo_o);
    else passes++;
    @(posedge clk_i); #1;
    refill_i = 1'b1; refill_cnt_i = 4'd5;
    @(posedge clk_i); #1;
    refill_sel_i = 2'd3;
    @(posedge clk_i); #1;
    refill_i = 1'b0;
    @(negedge clk_i);
    checks++;
    if ({inv_hi_o, inv_mid_o, inv_lo_o} !== 12'h44f)
      $display("[TB] FAIL refill_saturate: got %h, required 44f", {inv_hi_o, inv_mid_o, inv_lo_o});
    else passes++;
    @(posedge clk_i); #1;
    price_i = 5'd5; money_i = 5'd6; start_i = 1'b1; coin_ready_i = 1'b0;
    @(posedge clk_i); #1;
    start_i = 1'b0;
    @(posedge clk_i); #1;
    refill_i = 1'b1; refill_sel_i = 2'd2; refill_cnt_i = 4'd3;
    @(posedge clk_i); #1;
    refill_i = 1'b0;
    @(negedge clk_i);
    checks++;
    if ({coin_valid_o, inv_hi_o} !== {1'b1, 4'd4})
      $display("[TB] FAIL refill_busy: got valid %0d hi %0d, required 1 4", coin_valid_o, inv_hi_o);
    else passes++;
    rst_n_i = 1'b0;
    @(posedge clk_i); #1;
    rst_n_i = 1'b1;
    @(negedge clk_i);
    checks++;
    if ({busy_o, coin_valid_o, coin_sel_o} !== 4'b0000)
      $display("[TB] FAIL mid_reset_state: got busy %0d valid %0d sel %0d, required 0 0 0", busy_o, coin_valid_o, coin_sel_o);
    else passes++;
    checks++;
    if ({inv_hi_o, inv_mid_o, inv_lo_o} !== 12'h444)
      $display("[TB] FAIL mid_reset_inv: got %h, required 444", {inv_hi_o, inv_mid_o, inv_lo_o});
    else passes++;
    @(posedge clk_i); #1;
    exp_q.push_back(COIN_MID);
    run_txn(5'd5, 5'd10, 0, 1'b0, 2'd0, 4'd0, d, s, r, fc, dc);
    checks++;
    if (s !== 1'b0) $display("[TB] FAIL after_reset_short: got %0d, required 0", s);
    else passes++;
  endtask

  initial begin
    test_reset();
    test_change();
    test_zero_and_refund();
    test_backpressure();
    test_shortfall();
    test_refill_and_reset();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
